// File: rtl/bexkat1_exceptions_pkg.sv
// Shared bexkat1 exception code definitions used across the CPU and its peripherals.
package bexkat1_exceptions_pkg;

  localparam logic [3:0] EXC_RESET    = 4'h0;
  localparam logic [3:0] EXC_ILLOP    = 4'h1;
  localparam logic [3:0] EXC_TIMER0   = 4'h2;
  localparam logic [3:0] EXC_TIMER1   = 4'h3;
  localparam logic [3:0] EXC_TIMER2   = 4'h4;
  localparam logic [3:0] EXC_TIMER3   = 4'h5;
  localparam logic [3:0] EXC_UART0_RX = 4'h6;
  localparam logic [3:0] EXC_UART0_TX = 4'h7;
  localparam logic [3:0] EXC_MMU      = 4'h8;

endpackage

// File: rtl/bexkat1_intr_pkg.sv
// Types and helpers for the CPU-side interrupt acceptor: state encoding,
// acknowledge vector layout and the exception-code to acknowledge-bit mapping.
package bexkat1_intr_pkg;
  import bexkat1_exceptions_pkg::*;

  localparam int unsigned TIMER_N  = 4;
  localparam int unsigned SERIAL_N = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ACK,
    ST_INSERVICE,
    ST_HOLD
  } intr_state_t;

  typedef struct packed {
    logic [TIMER_N-1:0]  timer;
    logic [SERIAL_N-1:0] serial0;
    logic                mmu;
  } ack_vec_t;

  // Codes that do not belong to a known source map to an all-zero vector.
  function automatic ack_vec_t code_to_ack(input logic [3:0] code);
    ack_vec_t v;
    v = '0;
    case (code)
      EXC_TIMER0:   v.timer[0]   = 1'b1;
      EXC_TIMER1:   v.timer[1]   = 1'b1;
      EXC_TIMER2:   v.timer[2]   = 1'b1;
      EXC_TIMER3:   v.timer[3]   = 1'b1;
      EXC_UART0_TX: v.serial0[0] = 1'b1;
      EXC_UART0_RX: v.serial0[1] = 1'b1;
      EXC_MMU:      v.mmu        = 1'b1;
      default:      v            = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/interrupt_acceptor_if.sv
// CPU-side interrupt handshake: request/code towards the core, enable/ack/done back.
interface interrupt_acceptor_if;

  logic       enabled_i;
  logic       int_ack_i;
  logic       int_done_i;
  logic       int_req_o;
  logic [3:0] int_code_o;

  modport master (
    input  enabled_i,
    input  int_ack_i,
    input  int_done_i,
    output int_req_o,
    output int_code_o
  );

  modport slave (
    output enabled_i,
    output int_ack_i,
    output int_done_i,
    input  int_req_o,
    input  int_code_o
  );

endinterface

// File: rtl/interrupt_acceptor_ack_decode.sv
// Combinational decode of an exception code into per-source one-hot acknowledges,
// gated by a strobe so nothing is driven outside the acknowledge window.
module interrupt_ack_decode
  import bexkat1_intr_pkg::*;
(
  input  logic [3:0]          code,
  input  logic                strobe,
  output logic [TIMER_N-1:0]  timer_ack,
  output logic [SERIAL_N-1:0] serial0_ack,
  output logic                mmu_ack
);

  ack_vec_t vec;

  always_comb begin
    // NOTE: default every combinational output first so no path can infer a latch.
    vec = '0;
    if (strobe) vec = code_to_ack(code);
  end

  assign timer_ack   = vec.timer;
  assign serial0_ack = vec.serial0;
  assign mmu_ack     = vec.mmu;

endmodule

// File: rtl/interrupt_acceptor.sv
// Presents one prioritised exception at a time to the bexkat1 core, pulses the
// originating source's acknowledge, then blocks until handler completion plus hold-off.
module interrupt_acceptor
  import bexkat1_exceptions_pkg::*;
  import bexkat1_intr_pkg::*;
#(
  parameter int unsigned ACK_CYCLES = 1,
  parameter int unsigned HOLDOFF    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [3:0]          exc_code_i,
  interrupt_acceptor_if.master cpu,
  output logic [TIMER_N-1:0]  timer_ack_o,
  output logic [SERIAL_N-1:0] serial0_ack_o,
  output logic                mmu_ack_o,
  output logic                busy_o
);

  localparam int unsigned ACK_W  = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam int unsigned HOLD_W = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

  intr_state_t         state;
  logic                int_req_q;
  logic [3:0]          int_code_q;
  logic [ACK_W-1:0]    ack_cnt;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                ack_strobe;
  logic [TIMER_N-1:0]  timer_ack_d;
  logic [SERIAL_N-1:0] serial0_ack_d;
  logic                mmu_ack_d;

  // High whenever the next cycle is an acknowledge cycle, so the registered
  // pulse lines up exactly with the ACK state.
  assign ack_strobe = (state == ST_REQ && cpu.int_ack_i) ||
                      (state == ST_ACK && ack_cnt != '0);

  interrupt_ack_decode u_decode (
    .code        (int_code_q),
    .strobe      (ack_strobe),
    .timer_ack   (timer_ack_d),
    .serial0_ack (serial0_ack_d),
    .mmu_ack     (mmu_ack_d)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= ST_IDLE;
      int_req_q     <= 1'b0;
      int_code_q    <= EXC_RESET;
      ack_cnt       <= '0;
      hold_cnt      <= '0;
      busy_o        <= 1'b0;
      timer_ack_o   <= '0;
      serial0_ack_o <= '0;
      mmu_ack_o     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge values of the others.
      timer_ack_o   <= timer_ack_d;
      serial0_ack_o <= serial0_ack_d;
      mmu_ack_o     <= mmu_ack_d;

      unique case (state)
        ST_IDLE: begin
          if (cpu.enabled_i && exc_code_i != EXC_RESET) begin
            state      <= ST_REQ;
            int_req_q  <= 1'b1;
            int_code_q <= exc_code_i;
            busy_o     <= 1'b1;
          end
        end

        ST_REQ: begin
          // An ack in the same cycle as a disable still completes the handshake.
          if (cpu.int_ack_i) begin
            state     <= ST_ACK;
            int_req_q <= 1'b0;
            ack_cnt   <= ACK_W'(ACK_CYCLES - 1);
          end else if (!cpu.enabled_i) begin
            state      <= ST_IDLE;
            int_req_q  <= 1'b0;
            int_code_q <= EXC_RESET;
            busy_o     <= 1'b0;
          end
        end

        ST_ACK: begin
          if (ack_cnt == '0) state <= ST_INSERVICE;
          else               ack_cnt <= ack_cnt - 1'b1;
        end

        ST_INSERVICE: begin
          if (cpu.int_done_i) begin
            int_code_q <= EXC_RESET;
            if (HOLDOFF > 0) begin
              state    <= ST_HOLD;
              hold_cnt <= HOLD_W'(HOLDOFF);
            end else begin
              state  <= ST_IDLE;
              busy_o <= 1'b0;
            end
          end
        end

        ST_HOLD: begin
          if (hold_cnt <= HOLD_W'(1)) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            busy_o   <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end

        default: begin
          state     <= ST_IDLE;
          int_req_q <= 1'b0;
          busy_o    <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.int_req_o  = int_req_q;
  assign cpu.int_code_o = int_code_q;

endmodule

// File: tb/tb_interrupt_acceptor.sv
// Self-checking bench for interrupt_acceptor: three builds (default, ACK_CYCLES=4,
// HOLDOFF=0) share one stimulus stream and are compared against a transaction-level model.
module tb_interrupt_acceptor;
  import bexkat1_exceptions_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] exc_code = EXC_RESET;
  logic       enabled  = 1'b0;
  logic       int_ack  = 1'b0;
  logic       int_done = 1'b0;

  always #5 clk = ~clk;

  interrupt_acceptor_if if_main ();
  interrupt_acceptor_if if_a4 ();
  interrupt_acceptor_if if_h0 ();

  assign if_main.enabled_i  = enabled;
  assign if_main.int_ack_i  = int_ack;
  assign if_main.int_done_i = int_done;
  assign if_a4.enabled_i    = enabled;
  assign if_a4.int_ack_i    = int_ack;
  assign if_a4.int_done_i   = int_done;
  assign if_h0.enabled_i    = enabled;
  assign if_h0.int_ack_i    = int_ack;
  assign if_h0.int_done_i   = int_done;

  logic [3:0] t_ack [3];
  logic [1:0] s_ack [3];
  logic       m_ack [3];
  logic       busy  [3];

  interrupt_acceptor #(.ACK_CYCLES(1), .HOLDOFF(2)) u_main (
    .clk_i(clk), .rst_i(rst), .exc_code_i(exc_code), .cpu(if_main),
    .timer_ack_o(t_ack[0]), .serial0_ack_o(s_ack[0]), .mmu_ack_o(m_ack[0]), .busy_o(busy[0]));

  interrupt_acceptor #(.ACK_CYCLES(4), .HOLDOFF(2)) u_a4 (
    .clk_i(clk), .rst_i(rst), .exc_code_i(exc_code), .cpu(if_a4),
    .timer_ack_o(t_ack[1]), .serial0_ack_o(s_ack[1]), .mmu_ack_o(m_ack[1]), .busy_o(busy[1]));

  interrupt_acceptor #(.ACK_CYCLES(1), .HOLDOFF(0)) u_h0 (
    .clk_i(clk), .rst_i(rst), .exc_code_i(exc_code), .cpu(if_h0),
    .timer_ack_o(t_ack[2]), .serial0_ack_o(s_ack[2]), .mmu_ack_o(m_ack[2]), .busy_o(busy[2]));

  logic       obs_req  [3];
  logic [3:0] obs_code [3];
  logic [6:0] obs_ack  [3];

  assign obs_req[0]  = if_main.int_req_o;
  assign obs_req[1]  = if_a4.int_req_o;
  assign obs_req[2]  = if_h0.int_req_o;
  assign obs_code[0] = if_main.int_code_o;
  assign obs_code[1] = if_a4.int_code_o;
  assign obs_code[2] = if_h0.int_code_o;
  assign obs_ack[0]  = {t_ack[0], s_ack[0], m_ack[0]};
  assign obs_ack[1]  = {t_ack[1], s_ack[1], m_ack[1]};
  assign obs_ack[2]  = {t_ack[2], s_ack[2], m_ack[2]};

  // Acknowledge bit i of {timer[3:0], serial0[1:0], mmu} belongs to SRC_CODE[i].
  localparam logic [3:0] SRC_CODE [7] = '{EXC_MMU, EXC_UART0_TX, EXC_UART0_RX,
                                          EXC_TIMER0, EXC_TIMER1, EXC_TIMER2, EXC_TIMER3};
  localparam int ACK_P  [3] = '{1, 4, 1};
  localparam int HOLD_P [3] = '{2, 2, 0};

  // Transaction-level view: what is pending, how many ack clocks remain,
  // whether the handler is running, and how many hold-off clocks remain.
  typedef struct {
    logic [3:0] code;
    bit         req;
    int         ack_left;
    bit         in_service;
    int         hold_left;
  } model_t;

  model_t m [3];

  typedef struct {
    logic [3:0] code;
    bit         en;
    bit         ack;
    bit         done;
    bit         e_req;
    logic [3:0] e_code;
    logic [6:0] e_ack;
    bit         e_busy;
  } vec_t;

  vec_t tbl [9];

  int checks = 0;
  int errors = 0;

  function automatic logic [6:0] exp_ack(logic [3:0] code);
    logic [6:0] v;
    v = '0;
    for (int i = 0; i < 7; i++) if (code == SRC_CODE[i]) v[i] = 1'b1;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m[k].code = EXC_RESET;
      m[k].req = 1'b0;
      m[k].ack_left = 0;
      m[k].in_service = 1'b0;
      m[k].hold_left = 0;
    end
  endtask

  task automatic model_step(int k);
    if (m[k].hold_left > 0) begin
      m[k].hold_left--;
    end else if (m[k].in_service) begin
      if (int_done) begin
        m[k].in_service = 1'b0;
        m[k].code = EXC_RESET;
        m[k].hold_left = HOLD_P[k];
      end
    end else if (m[k].ack_left > 0) begin
      m[k].ack_left--;
      if (m[k].ack_left == 0) m[k].in_service = 1'b1;
    end else if (m[k].req) begin
      if (int_ack) begin
        m[k].req = 1'b0;
        m[k].ack_left = ACK_P[k];
      end else if (!enabled) begin
        m[k].req = 1'b0;
        m[k].code = EXC_RESET;
      end
    end else if (enabled && exc_code != EXC_RESET) begin
      m[k].req = 1'b1;
      m[k].code = exc_code;
    end
  endtask

  task automatic compare_all(string tag);
    for (int k = 0; k < 3; k++) begin
      bit e_busy;
      e_busy = m[k].req || m[k].ack_left > 0 || m[k].in_service || m[k].hold_left > 0;
      check($sformatf("%s d%0d req", tag, k), 32'(obs_req[k]), 32'(m[k].req));
      check($sformatf("%s d%0d code", tag, k), 32'(obs_code[k]), 32'(m[k].code));
      check($sformatf("%s d%0d ack", tag, k), 32'(obs_ack[k]),
            32'((m[k].ack_left > 0) ? exp_ack(m[k].code) : 7'd0));
      check($sformatf("%s d%0d busy", tag, k), 32'(busy[k]), 32'(e_busy));
    end
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b0;
    enabled = 1'b0;
    int_ack = 1'b0;
    int_done = 1'b0;
    exc_code = EXC_RESET;
    model_reset();
    #2;
    compare_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Basic handshake on the default build: outputs observed one clock after each row's inputs.
    tbl[0] = '{EXC_TIMER2, 1, 0, 0, 1, EXC_TIMER2, 7'd0, 1};
    tbl[1] = '{EXC_TIMER2, 1, 0, 0, 1, EXC_TIMER2, 7'd0, 1};
    tbl[2] = '{EXC_TIMER2, 1, 0, 0, 1, EXC_TIMER2, 7'd0, 1};
    tbl[3] = '{EXC_TIMER2, 1, 1, 0, 0, EXC_TIMER2, {4'b0100, 2'b00, 1'b0}, 1};
    tbl[4] = '{EXC_TIMER2, 1, 0, 0, 0, EXC_TIMER2, 7'd0, 1};
    tbl[5] = '{EXC_RESET,  1, 0, 1, 0, EXC_RESET,  7'd0, 1};
    tbl[6] = '{EXC_RESET,  1, 0, 0, 0, EXC_RESET,  7'd0, 1};
    tbl[7] = '{EXC_RESET,  1, 0, 0, 0, EXC_RESET,  7'd0, 0};
    tbl[8] = '{EXC_RESET,  1, 1, 1, 0, EXC_RESET,  7'd0, 0};

    do_reset("reset");
    for (int i = 0; i < 9; i++) begin
      exc_code = tbl[i].code;
      enabled  = tbl[i].en;
      int_ack  = tbl[i].ack;
      int_done = tbl[i].done;
      tick($sformatf("t1 row%0d", i));
      check($sformatf("t1 row%0d req", i),  32'(obs_req[0]),  32'(tbl[i].e_req));
      check($sformatf("t1 row%0d code", i), 32'(obs_code[0]), 32'(tbl[i].e_code));
      check($sformatf("t1 row%0d ack", i),  32'(obs_ack[0]),  32'(tbl[i].e_ack));
      check($sformatf("t1 row%0d busy", i), 32'(busy[0]),     32'(tbl[i].e_busy));
    end

    // Priority freeze: a higher-priority code arriving during REQ is ignored.
    do_reset("t2 reset");
    exc_code = EXC_UART0_TX; enabled = 1'b1;
    tick("t2 req");
    exc_code = EXC_TIMER3;
    tick("t2 hold1");
    tick("t2 hold2");
    check("t2 frozen code", 32'(obs_code[0]), 32'(EXC_UART0_TX));
    int_ack = 1'b1;
    tick("t2 ack");
    check("t2 serial ack", 32'(s_ack[0]), 32'(2'b01));
    check("t2 timer ack", 32'(t_ack[0]), 32'(4'b0000));
    int_ack = 1'b0;
    tick("t2 svc");

    // Withdrawal, then ack winning over a simultaneous disable.
    do_reset("t3 reset");
    exc_code = EXC_MMU; enabled = 1'b1;
    tick("t3 req");
    enabled = 1'b0;
    tick("t3 withdraw");
    check("t3 withdraw req", 32'(obs_req[0]), 32'(1'b0));
    check("t3 withdraw busy", 32'(busy[0]), 32'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick("t3 idle");
      check("t3 no mmu ack", 32'(m_ack[0]), 32'(1'b0));
    end
    enabled = 1'b1;
    tick("t3 req2");
    int_ack = 1'b1; enabled = 1'b0;
    tick("t3 ack wins");
    check("t3 mmu ack", 32'(m_ack[0]), 32'(1'b1));
    int_ack = 1'b0;
    tick("t3 after");
    check("t3 mmu ack end", 32'(m_ack[0]), 32'(1'b0));

    // Hold-off and re-request with the source held asserted.
    do_reset("t4 reset");
    exc_code = EXC_UART0_RX; enabled = 1'b1;
    tick("t4 req");
    int_ack = 1'b1;
    tick("t4 ack");
    int_ack = 1'b0;
    tick("t4 svc");
    int_done = 1'b1;
    tick("t4 done");
    check("t4 hold req0", 32'(obs_req[0]), 32'(1'b0));
    int_done = 1'b0;
    tick("t4 hold");
    check("t4 hold req1", 32'(obs_req[0]), 32'(1'b0));
    tick("t4 idle");
    check("t4 idle req", 32'(obs_req[0]), 32'(1'b0));
    tick("t4 rereq");
    check("t4 rereq req", 32'(obs_req[0]), 32'(1'b1));
    check("t4 rereq code", 32'(obs_code[0]), 32'(EXC_UART0_RX));

    // Asynchronous reset during the second acknowledge clock of the ACK_CYCLES=4 build.
    do_reset("t5 reset");
    exc_code = EXC_TIMER1; enabled = 1'b1;
    tick("t5 req");
    int_ack = 1'b1;
    tick("t5 ack1");
    int_ack = 1'b0;
    tick("t5 ack2");
    check("t5 ack2 pulse", 32'(t_ack[1]), 32'(4'b0010));
    #1 rst = 1'b0;
    #1 check("t5 async truncate", 32'(t_ack[1]), 32'(4'b0000));
    do_reset("t5 in reset");
    tick("t5 release");
    check("t5 release req", 32'(obs_req[1]), 32'(1'b0));
    check("t5 release code", 32'(obs_code[1]), 32'(EXC_RESET));
    check("t5 release busy", 32'(busy[1]), 32'(1'b0));

    // Spurious inputs in IDLE, then an idle code held for 20 clocks.
    do_reset("t6 reset");
    enabled = 1'b1; exc_code = EXC_RESET; int_ack = 1'b1; int_done = 1'b1;
    tick("t6 spurious");
    check("t6 spurious busy", 32'(busy[0]), 32'(1'b0));
    int_ack = 1'b0; int_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick("t6 idle code");
      check("t6 idle req", 32'(obs_req[0]), 32'(1'b0));
    end

    // HOLDOFF=0 build accepts on the cycle right after done; default build is still holding.
    exc_code = EXC_MMU;
    tick("t6 req");
    int_ack = 1'b1;
    tick("t6 ack");
    int_ack = 1'b0;
    tick("t6 svc");
    int_done = 1'b1;
    tick("t6 done");
    check("t6 h0 idle", 32'(busy[2]), 32'(1'b0));
    int_done = 1'b0;
    tick("t6 resample");
    check("t6 h0 rereq", 32'(obs_req[2]), 32'(1'b1));
    check("t6 main holding", 32'(obs_req[0]), 32'(1'b0));

    // Randomized traffic, including out-of-range codes and occasional resets.
    do_reset("rnd reset");
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(99) == 0) do_reset("rnd reset");
      enabled  = ($urandom_range(9) < 8);
      exc_code = ($urandom_range(3) == 0) ? EXC_RESET : 4'($urandom_range(15));
      int_ack  = ($urandom_range(9) < 3);
      int_done = ($urandom_range(9) < 2);
      tick("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_acceptor.md
Name: interrupt_acceptor

Overview:
- CPU-side end of the interrupt path: consumes the prioritised exception code from the interrupt encoder and presents one request at a time to the bexkat1 core.
- Holds the request through a req/ack handshake, then decodes the accepted code back into a one-hot acknowledge pulse to the originating source (timers, UART0, MMU).
- Blocks further requests until the handler signals completion, plus a hold-off for source deassert latency.

Parameters:
ACK_CYCLES, 1, width in clocks of the per-source acknowledge pulse (>=1)
HOLDOFF, 2, clocks after int_done_i before a new code is sampled (>=0)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous reset, active-low
exc_code_i  input  4  prioritised exception code from the encoder; EXC_RESET means none pending
enabled_i  input  1  CPU global interrupt enable
int_ack_i  input  1  CPU has taken the vector in int_code_o
int_done_i  input  1  CPU returned from the handler (one-clock pulse)
int_req_o  output  1  interrupt request to CPU
int_code_o  output  4  latched exception code, stable while int_req_o=1
timer_ack_o  output  4  one-hot ack, bit n for EXC_TIMERn
serial0_ack_o  output  2  bit1 = EXC_UART0_RX, bit0 = EXC_UART0_TX
mmu_ack_o  output  1  ack for EXC_MMU
busy_o  output  1  1 in every state except IDLE

Behaviour:
- Reset (rst_i=0, async): state IDLE, int_req_o=0, int_code_o=EXC_RESET, all ack outputs 0, busy_o=0, counters 0. A reset during ACK truncates the pulse immediately.
- All outputs are registered.
- States: IDLE, REQ, ACK, INSERVICE, HOLD.
- IDLE:
  - On a rising edge with enabled_i=1 and exc_code_i!=EXC_RESET: latch exc_code_i into int_code_o and enter REQ.
  - int_req_o=1 from the next cycle (1-clock latency).
  - Any other condition: stay in IDLE.
- REQ:
  - int_req_o=1; int_code_o frozen. Changes on exc_code_i are ignored, including higher-priority codes.
  - int_ack_i=1: int_req_o=0 next cycle; enter ACK.
  - enabled_i=0 with int_ack_i=0: withdraw. int_req_o=0 next cycle, int_code_o returns to EXC_RESET, enter IDLE, no ack pulse.
  - int_ack_i=1 and enabled_i=0 in the same cycle: ack wins.
- ACK:
  - The decoded ack bit for int_code_o is high for exactly ACK_CYCLES clocks, then the state is INSERVICE.
  - Codes outside the seven source codes drive no ack bit but still follow the same timing.
  - At most one ack bit is high at any time.
- INSERVICE: wait for int_done_i=1.
  - HOLDOFF>0: enter HOLD with counter=HOLDOFF.
  - HOLDOFF=0: enter IDLE directly.
  - int_code_o resets to EXC_RESET on leaving INSERVICE.
- HOLD: decrement counter each clock; at 1, enter IDLE. IDLE samples exc_code_i on the first cycle after HOLD.
- Ignored inputs:
  - int_ack_i outside REQ.
  - int_done_i outside INSERVICE, including int_done_i arriving during ACK.
- Sampling: exc_code_i is sampled only in IDLE. A source still asserted after hold-off re-requests.

Decomposition:
- Package bexkat1_intr_pkg holds:
  - the state enum;
  - ACK vector widths (TIMER_N=4, SERIAL_N=2);
  - a code-to-ack-bit mapping function.
- Exception code constants (EXC_*) come from the shared bexkat1 exceptions definitions; none are redefined.
- One sub-module is natural: interrupt_ack_decode.
  - Combinational, maps a 4-bit code plus a strobe to {timer_ack, serial0_ack, mmu_ack}.
  - The top level registers its outputs.

Test Plan:
1. Basic handshake: reset release, enabled_i=1, exc_code_i=EXC_TIMER2 at cycle 0; int_ack_i pulsed at cycle 3.
   - int_req_o=1 in cycles 1-3 with int_code_o=EXC_TIMER2.
   - timer_ack_o=4'b0100 for 1 clock at cycle 4.
   - busy_o=1 until int_done_i plus 2 clocks.
2. Priority freeze: while in REQ for EXC_UART0_TX, drive exc_code_i=EXC_TIMER3.
   - int_code_o stays EXC_UART0_TX.
   - After ack, serial0_ack_o=2'b01 and timer_ack_o=0.
3. Withdrawal: in REQ for EXC_MMU, drop enabled_i with no ack.
   - int_req_o=0 next cycle, mmu_ack_o never asserts, busy_o=0.
   - Repeat with int_ack_i and enabled_i dropping in the same cycle: mmu_ack_o pulses.
4. Hold-off and re-request: EXC_UART0_RX held continuously through int_done_i.
   - No new int_req_o for 2 clocks after done.
   - int_req_o then reasserts with int_code_o=EXC_UART0_RX.
5. Reset mid-operation: ACK_CYCLES=4, assert rst_i=0 during the second ack clock.
   - timer_ack_o=0 immediately, without waiting for a clock edge.
   - After release: int_req_o=0, int_code_o=EXC_RESET, state IDLE.
6. Spurious inputs:
   - int_ack_i and int_done_i pulsed in IDLE: no state change.
   - exc_code_i=EXC_RESET with enabled_i=1 held 20 clocks: int_req_o stays 0.
   - HOLDOFF=0 build: a new request is accepted on the cycle after done.
